junction_scheduler: RTL and testbench
=====================================

JUNCTION_SCHEDULER -- requirements
Module: junction_scheduler

Interface
REQ-001 The block SHALL have these parameters, one per line (name, default, meaning); each value SHALL be ≥1 and ≤255, with MIN_GREEN ≤ MAX_GREEN.
- MIN_GREEN, 4: minimum green cycles per approach.
- MAX_GREEN, 10: green cycles after which extension stops.
- YELLOW_TIME, 3: yellow cycles.
- ALLRED_TIME, 2: all-red clearance cycles.
- WALK_TIME, 5: pedestrian walk cycles.
REQ-002 The block SHALL have these ports, one per line (name, direction, width, meaning):
- clk, input, 1: single clock; all state changes on its rising edge.
- clear, input, 1: reset, asynchronous, active-high.
- req, input, 4: vehicle detector per approach (level).
- light, output, 8: light[2i+1:2i] is the signal for approach i; red=2'b00, yellow=2'b01, green=2'b10.
- cur, output, 2: approach owning the current or most recent green.
- pend, output, 4: latched service requests.
- ped_req, input, 1: pedestrian button (only with PED_WALK_EN).
- walk, output, 1: pedestrian walk lamp (only with PED_WALK_EN).

Function
REQ-003 The block SHALL use the states ALLRED, GREEN, YELLOW and WALK; every output SHALL be registered.
REQ-004 pend[i] SHALL set on any cycle req[i]=1, except for i=cur while in GREEN.
REQ-005 pend[nxt] SHALL clear on the cycle GREEN is entered; clear SHALL win over a simultaneous set.
REQ-006 In GREEN, light SHALL show green for cur and red for all other approaches; the green counter g SHALL count from 1 and saturate at MAX_GREEN.
REQ-007 "Demand" SHALL mean pend has any bit set for an approach other than cur, or ped_pend=1.
REQ-008 GREEN SHALL exit to YELLOW when g ≥ MIN_GREEN AND demand AND (req[cur]=0 OR g ≥ MAX_GREEN).
REQ-009 With no demand, GREEN SHALL hold indefinitely.
REQ-010 On GREEN exit, nxt SHALL latch the round-robin winner among pend, searching from cur+1 mod 4; if pend is zero, nxt=cur.
REQ-011 YELLOW SHALL show yellow for cur for exactly YELLOW_TIME cycles, then go to ALLRED.
REQ-012 ALLRED SHALL show light=8'h00 for exactly ALLRED_TIME cycles.
REQ-013 At the end of ALLRED, the block SHALL go to WALK if ped_pend=1, otherwise to GREEN with cur←nxt.
REQ-014 No two approaches SHALL ever be non-red simultaneously.
REQ-015 Green SHALL never follow green without YELLOW and ALLRED in between.
REQ-016 The first ALLRED after reset SHALL last exactly ALLRED_TIME cycles.

Reset
REQ-017 While clear=1, the block SHALL asynchronously force state=ALLRED, light=8'h00, cur=0, nxt=0, pend=0, g=0, the timer loaded for ALLRED, walk=0 and ped_pend=0.
REQ-018 Reset asserted mid-phase, including mid-YELLOW or mid-WALK, SHALL take effect immediately with no partial phase completion.
REQ-019 After clear deasserts, the block SHALL give exactly ALLRED_TIME all-red cycles and then green to approach 0.

Configuration
REQ-020 With macro PED_WALK_EN defined, the block SHALL include ped_req, walk, ped_pend and the WALK state.
REQ-021 With PED_WALK_EN defined, ped_pend SHALL set on ped_req=1 and clear on WALK entry.
REQ-022 WALK SHALL hold light=8'h00 and walk=1 for WALK_TIME cycles, then run ALLRED (ALLRED_TIME) followed by GREEN for nxt.
REQ-023 Without PED_WALK_EN, the ports ped_req and walk and the WALK state SHALL be absent, ped_pend SHALL be constant 0, and the remaining behaviour SHALL be identical.

Verification (defaults)
REQ-024 Reset: assert clear mid-YELLOW -> light=8'h00 in the same cycle; release -> 2 all-red cycles, then light=8'h02, cur=0.
REQ-025 Single demand: approach 0 green, req=0; pulse req[2] at g=1 -> green until g=4, 3 yellow (light=8'h01), 2 all-red, then light=8'h20, cur=2, pend[2]=0.
REQ-026 Extension: req[0] held high, pend[1] set -> approach 0 green for exactly 10 cycles, then yellow.
REQ-027 Round-robin: pend=4'b1110 while approach 0 green -> served order 1, 2, 3; pend ends at 0.
REQ-028 Idle: no requests for 100 cycles -> light stays 8'h02, cur=0.
REQ-029 PED_WALK_EN: ped_req pulse at g=1 with pend=0 -> 3 yellow, 2 all-red, walk=1 for 5 cycles, 2 all-red, then approach 0 green; walk=0 whenever any light is non-red.

Source files
------------

// File: rtl/junction_scheduler.sv
// junction_scheduler: four-approach round-robin traffic light scheduler.
// Cycles GREEN -> YELLOW -> ALLRED -> GREEN. Each green lasts MIN_GREEN cycles
// and can be extended to MAX_GREEN while its own detector stays active.
// Defining the macro PED_WALK_EN adds a pedestrian WALK phase, plus the
// ped_req input and the walk output.
module junction_scheduler #(
  parameter int unsigned MIN_GREEN   = 4,
  parameter int unsigned MAX_GREEN   = 10,
  parameter int unsigned YELLOW_TIME = 3,
  parameter int unsigned ALLRED_TIME = 2,
  parameter int unsigned WALK_TIME   = 5
) (
  input  logic       clk,
  input  logic       clear,
  input  logic [3:0] req,
`ifdef PED_WALK_EN
  input  logic       ped_req,
  output logic       walk,
`endif
  output logic [7:0] light,
  output logic [1:0] cur,
  output logic [3:0] pend
);

  typedef enum logic [1:0] {
    ST_ALLRED = 2'd0,
    ST_GREEN  = 2'd1,
    ST_YELLOW = 2'd2
`ifdef PED_WALK_EN
    , ST_WALK = 2'd3
`endif
  } stateT;

  localparam logic [7:0] LP_MIN_G  = 8'(MIN_GREEN);
  localparam logic [7:0] LP_MAX_G  = 8'(MAX_GREEN);
  localparam logic [7:0] LP_YELLOW = 8'(YELLOW_TIME);
  localparam logic [7:0] LP_ALLRED = 8'(ALLRED_TIME);
`ifdef PED_WALK_EN
  localparam logic [7:0] LP_WALK   = 8'(WALK_TIME);
`endif

  stateT      r_state, w_stateNext;
  logic [7:0] r_timer, w_timerNext;
  logic [7:0] r_g, w_gNext;
  logic [7:0] r_light, w_lightNext;
  logic [1:0] r_cur, w_curNext;
  logic [1:0] r_nxt, w_nxtNext;
  logic [1:0] w_winner, w_probe;
  logic [3:0] r_pend, w_pendNext, w_curMask;
  logic       w_found, w_demand, w_pedPend, w_greenEntry;

`ifdef PED_WALK_EN
  logic r_pedPend, w_pedPendNext;
  logic r_walk, w_walkNext;
  assign w_pedPend = r_pedPend;
  assign walk      = r_walk;
`else
  assign w_pedPend = 1'b0;
`endif

  assign light = r_light;
  assign cur   = r_cur;
  assign pend  = r_pend;

  // Demand is any latched request that does not belong to the current green,
  // or a waiting pedestrian.
  assign w_curMask = 4'b0001 << r_cur;
  assign w_demand  = (|(r_pend & ~w_curMask)) | w_pedPend;

  // Round-robin search of pend, starting at cur+1. If nothing is pending,
  // the winner falls back to cur.
  always_comb begin
    w_winner = r_cur;
    w_found  = 1'b0;
    w_probe  = r_cur;
    for (int k = 1; k <= 4; k++) begin
      w_probe = r_cur + 2'(k);
      if (!w_found && r_pend[w_probe]) begin
        w_winner = w_probe;
        w_found  = 1'b1;
      end
    end
  end

  // Next-state logic: phase timers, green extension and selection of the next approach.
  always_comb begin
    w_stateNext = r_state;
    w_timerNext = r_timer;
    w_gNext     = r_g;
    w_curNext   = r_cur;
    w_nxtNext   = r_nxt;
    case (r_state)
      ST_GREEN: begin
        if (r_g < LP_MAX_G) w_gNext = r_g + 8'd1;
        if ((r_g >= LP_MIN_G) && w_demand && (!req[r_cur] || (r_g >= LP_MAX_G))) begin
          w_stateNext = ST_YELLOW;
          w_timerNext = LP_YELLOW;
          w_nxtNext   = w_winner;
        end
      end
      ST_YELLOW: begin
        if (r_timer <= 8'd1) begin
          w_stateNext = ST_ALLRED;
          w_timerNext = LP_ALLRED;
        end else begin
          w_timerNext = r_timer - 8'd1;
        end
      end
      ST_ALLRED: begin
        if (r_timer <= 8'd1) begin
`ifdef PED_WALK_EN
          if (r_pedPend) begin
            w_stateNext = ST_WALK;
            w_timerNext = LP_WALK;
          end else
`endif
          begin
            w_stateNext = ST_GREEN;
            w_curNext   = r_nxt;
            w_gNext     = 8'd1;
          end
        end else begin
          w_timerNext = r_timer - 8'd1;
        end
      end
`ifdef PED_WALK_EN
      ST_WALK: begin
        if (r_timer <= 8'd1) begin
          w_stateNext = ST_ALLRED;
          w_timerNext = LP_ALLRED;
        end else begin
          w_timerNext = r_timer - 8'd1;
        end
      end
`endif
      default: begin
        w_stateNext = ST_ALLRED;
        w_timerNext = LP_ALLRED;
      end
    endcase
  end

  // Request latching. The green approach's own detector is ignored, and a
  // clear on green entry takes priority over a set in the same cycle.
  always_comb begin
    w_greenEntry = (w_stateNext == ST_GREEN) && (r_state != ST_GREEN);
    w_pendNext   = r_pend | (req & ((r_state == ST_GREEN) ? ~w_curMask : 4'b1111));
    if (w_greenEntry) w_pendNext[r_nxt] = 1'b0;
  end

`ifdef PED_WALK_EN
  // Pedestrian latch: set by the button, cleared on entry to WALK.
  always_comb begin
    w_pedPendNext = r_pedPend | ped_req;
    if ((w_stateNext == ST_WALK) && (r_state != ST_WALK)) w_pedPendNext = 1'b0;
    w_walkNext = (w_stateNext == ST_WALK);
  end
`endif

  // Lamp pattern for the next state. It is registered so the outputs are glitch-free.
  always_comb begin
    w_lightNext = 8'h00;
    case (w_stateNext)
      ST_GREEN:  w_lightNext[{w_curNext, 1'b0} +: 2] = 2'b10;
      ST_YELLOW: w_lightNext[{w_curNext, 1'b0} +: 2] = 2'b01;
      default:   w_lightNext = 8'h00;
    endcase
  end

  // State and output registers. Clear forces an immediate all-red restart.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      r_state   <= ST_ALLRED;
      r_timer   <= LP_ALLRED;
      r_g       <= 8'd0;
      r_light   <= 8'h00;
      r_cur     <= 2'd0;
      r_nxt     <= 2'd0;
      r_pend    <= 4'b0000;
`ifdef PED_WALK_EN
      r_pedPend <= 1'b0;
      r_walk    <= 1'b0;
`endif
    end else begin
      r_state   <= w_stateNext;
      r_timer   <= w_timerNext;
      r_g       <= w_gNext;
      r_light   <= w_lightNext;
      r_cur     <= w_curNext;
      r_nxt     <= w_nxtNext;
      r_pend    <= w_pendNext;
`ifdef PED_WALK_EN
      r_pedPend <= w_pedPendNext;
      r_walk    <= w_walkNext;
`endif
    end
  end

endmodule

// File: tb/tb_junction_scheduler.sv
// tb_junction_scheduler: directed self-checking bench for junction_scheduler.
// The pedestrian checks are built only when PED_WALK_EN is defined.
module tb_junction_scheduler;

  logic       clk;
  logic       clear;
  logic [3:0] req;
  logic [7:0] light;
  logic [1:0] cur;
  logic [3:0] pend;
  logic       pedReq;
`ifdef PED_WALK_EN
  logic       walk;
`endif

  int errors;
  int checks;

  junction_scheduler dut (
    .clk     (clk),
    .clear   (clear),
    .req     (req),
`ifdef PED_WALK_EN
    .ped_req (pedReq),
    .walk    (walk),
`endif
    .light   (light),
    .cur     (cur),
    .pend    (pend)
  );

  // Free-running clock with a 10-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges, then settle 1 unit past the edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] r, input logic p);
    req    = r;
    pedReq = p;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    clear  = 1'b1;
    applyStimulus(4'b0000, 1'b0);

    // Reset state.
    tick(2);
    checkOutput("rst_light", 32'(light), 32'h00);
    checkOutput("rst_cur",   32'(cur),   32'h0);
    checkOutput("rst_pend",  32'(pend),  32'h0);
`ifdef PED_WALK_EN
    checkOutput("rst_walk",  32'(walk),  32'h0);
`endif

    // After release: two all-red cycles, then approach 0 goes green.
    clear = 1'b0;
    tick(1);
    checkOutput("start_allred", 32'(light), 32'h00);
    tick(1);
    checkOutput("start_green", 32'(light), 32'h02);
    checkOutput("start_cur",   32'(cur),   32'h0);

    // Single demand: a one-cycle pulse on req[2] at g=1.
    applyStimulus(4'b0100, 1'b0);
    tick(1);
    applyStimulus(4'b0000, 1'b0);
    checkOutput("sd_pend_set", 32'(pend), 32'h4);
    tick(2);
    checkOutput("sd_green_g4", 32'(light), 32'h02);
    tick(1);
    checkOutput("sd_yellow1", 32'(light), 32'h01);
    tick(2);
    checkOutput("sd_yellow3", 32'(light), 32'h01);
    tick(1);
    checkOutput("sd_allred1", 32'(light), 32'h00);
    tick(1);
    checkOutput("sd_allred2", 32'(light), 32'h00);
    tick(1);
    checkOutput("sd_green2", 32'(light), 32'h20);
    checkOutput("sd_cur2",   32'(cur),   32'h2);
    checkOutput("sd_pend0",  32'(pend),  32'h0);

    // Assert clear in the middle of yellow; it must act before the next edge.
    applyStimulus(4'b0001, 1'b0);
    tick(1);
    applyStimulus(4'b0000, 1'b0);
    tick(2);
    checkOutput("mr_green_g4", 32'(light), 32'h20);
    tick(1);
    checkOutput("mr_yellow", 32'(light), 32'h10);
    tick(1);
    clear = 1'b1;
    #1;
    checkOutput("mr_async_light", 32'(light), 32'h00);
    checkOutput("mr_async_cur",   32'(cur),   32'h0);
    checkOutput("mr_async_pend",  32'(pend),  32'h0);
    tick(1);
    clear = 1'b0;
    tick(1);
    checkOutput("mr_allred2", 32'(light), 32'h00);
    tick(1);
    checkOutput("mr_green0", 32'(light), 32'h02);
    checkOutput("mr_cur0",   32'(cur),   32'h0);

    // Idle: approach 0 keeps green when nothing is requested.
    for (int i = 0; i < 100; i++) begin
      tick(1);
      checkOutput("idle_light", 32'(light), 32'h02);
    end
    checkOutput("idle_cur",  32'(cur),  32'h0);
    checkOutput("idle_pend", 32'(pend), 32'h0);

    // Round robin: pend=1110 while approach 0 is green (g already saturated).
    applyStimulus(4'b1110, 1'b0);
    tick(1);
    applyStimulus(4'b0000, 1'b0);
    checkOutput("rr_pend", 32'(pend), 32'hE);
    checkOutput("rr_hold", 32'(light), 32'h02);
    tick(1);
    checkOutput("rr_yellow0", 32'(light), 32'h01);
    tick(5);
    checkOutput("rr_green1", 32'(light), 32'h08);
    checkOutput("rr_cur1",   32'(cur),   32'h1);
    checkOutput("rr_pend1",  32'(pend),  32'hC);
    tick(4);
    checkOutput("rr_yellow1", 32'(light), 32'h04);
    tick(5);
    checkOutput("rr_green2", 32'(light), 32'h20);
    checkOutput("rr_cur2",   32'(cur),   32'h2);
    checkOutput("rr_pend2",  32'(pend),  32'h8);
    tick(9);
    checkOutput("rr_green3", 32'(light), 32'h80);
    checkOutput("rr_cur3",   32'(cur),   32'h3);
    checkOutput("rr_pend3",  32'(pend),  32'h0);
    tick(20);
    checkOutput("rr_hold3", 32'(light), 32'h80);

    // Move back to approach 0, then test the extension up to MAX_GREEN.
    applyStimulus(4'b0001, 1'b0);
    tick(1);
    applyStimulus(4'b0000, 1'b0);
    tick(1);
    checkOutput("ex_yellow3", 32'(light), 32'h40);
    tick(5);
    checkOutput("ex_green0", 32'(light), 32'h02);
    checkOutput("ex_cur0",   32'(cur),   32'h0);
    applyStimulus(4'b0011, 1'b0);
    tick(1);
    applyStimulus(4'b0001, 1'b0);
    checkOutput("ex_pend_own_masked", 32'(pend), 32'h2);
    tick(8);
    checkOutput("ex_green_g10", 32'(light), 32'h02);
    checkOutput("ex_pend_g10",  32'(pend),  32'h2);
    tick(1);
    applyStimulus(4'b0000, 1'b0);
    checkOutput("ex_yellow", 32'(light), 32'h01);
    checkOutput("ex_pend_yellow", 32'(pend), 32'h2);

`ifdef PED_WALK_EN
    // Pedestrian phase, starting from a fresh approach-0 green with pend=0.
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    tick(2);
    checkOutput("pw_green0", 32'(light), 32'h02);
    applyStimulus(4'b0000, 1'b1);
    tick(1);
    applyStimulus(4'b0000, 1'b0);
    checkOutput("pw_walk_green", 32'(walk), 32'h0);
    tick(2);
    checkOutput("pw_green_g4", 32'(light), 32'h02);
    tick(1);
    checkOutput("pw_yellow", 32'(light), 32'h01);
    checkOutput("pw_walk_yellow", 32'(walk), 32'h0);
    tick(3);
    checkOutput("pw_allred", 32'(light), 32'h00);
    checkOutput("pw_walk_allred", 32'(walk), 32'h0);
    tick(2);
    checkOutput("pw_walk_on", 32'(walk), 32'h1);
    checkOutput("pw_walk_light", 32'(light), 32'h00);
    tick(4);
    checkOutput("pw_walk_last", 32'(walk), 32'h1);
    tick(1);
    checkOutput("pw_walk_off", 32'(walk), 32'h0);
    checkOutput("pw_allred2", 32'(light), 32'h00);
    tick(2);
    checkOutput("pw_green_back", 32'(light), 32'h02);
    checkOutput("pw_cur_back",   32'(cur),   32'h0);
    checkOutput("pw_walk_final", 32'(walk),  32'h0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
